// File: rtl/collatz_sweep_if.sv
// rtl/collatz_sweep_if.sv - handshake bundle between the sweep sequencer and the Collatz compute core
//
// Signals:
//   core_start      sequencer -> core  1-cycle pulse: load core_num and compute
//   core_num        sequencer -> core  seed presented to the core
//   core_done       core -> sequencer  1-cycle pulse: results valid this cycle
//   core_orbit_len  core -> sequencer  orbit length of the finished seed
//   core_path_rec   core -> sequencer  path record (largest value reached)
//   core_overflow   core -> sequencer  finished seed overflowed BITS
// Modports: master = sequencer side, slave = core side.

interface collatz_sweep_if #(
  parameter int BITS      = 32,
  parameter int OLEN_BITS = 16
);
  logic                 core_start;
  logic [BITS-1:0]      core_num;
  logic                 core_done;
  logic [OLEN_BITS-1:0] core_orbit_len;
  logic [BITS-1:0]      core_path_rec;
  logic                 core_overflow;

  modport master (
    output core_start, core_num,
    input  core_done, core_orbit_len, core_path_rec, core_overflow
  );

  modport slave (
    input  core_start, core_num,
    output core_done, core_orbit_len, core_path_rec, core_overflow
  );
endinterface

// File: rtl/collatz_sweep.sv
// rtl/collatz_sweep.sv - sweep sequencer that runs the Collatz core over a seed range and keeps the longest orbit
//
// Optional feature macro: COLLATZ_SWEEP_PEAK_EN (adds o_peak_seed / o_peak_rec).
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          1-cycle pulse, begins a sweep from IDLE or DONE
//   i_abort          level, returns to IDLE next cycle (wins over start/core_done)
//   i_seed_base      first seed, sampled on start
//   i_count          number of seeds, sampled on start
//   core             core handshake bundle (master side)
//   o_busy           high in LAUNCH / WAIT / RECORD
//   o_done           high in DONE
//   o_best_seed      seed with the longest non-overflow orbit so far
//   o_best_len       its orbit length
//   o_ovf_cnt        overflowed seeds, saturating at 255
//   o_wrapped        sweep stopped early at the all-ones seed
//   o_peak_seed      (macro only) seed with the largest non-overflow path record
//   o_peak_rec       (macro only) that path record

module collatz_sweep #(
  parameter int BITS      = 32,
  parameter int OLEN_BITS = 16,
  parameter int CNT_BITS  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [BITS-1:0]      i_seed_base,
  input  logic [CNT_BITS-1:0]  i_count,
  collatz_sweep_if.master      core,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [BITS-1:0]      o_best_seed,
  output logic [OLEN_BITS-1:0] o_best_len,
  output logic [7:0]           o_ovf_cnt,
  output logic                 o_wrapped
`ifdef COLLATZ_SWEEP_PEAK_EN
  ,
  output logic [BITS-1:0]      o_peak_seed,
  output logic [BITS-1:0]      o_peak_rec
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RECORD = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]           r_state;
  logic [BITS-1:0]      r_num;
  logic [CNT_BITS-1:0]  r_remaining;
  logic [BITS-1:0]      r_best_seed;
  logic [OLEN_BITS-1:0] r_best_len;
  logic [7:0]           r_ovf_cnt;
  logic                 r_wrapped;
  // Core results are captured on core_done and consumed in RECORD.
  logic [OLEN_BITS-1:0] r_res_len;
  logic                 r_res_ovf;
`ifdef COLLATZ_SWEEP_PEAK_EN
  logic [BITS-1:0]      r_res_rec;
  logic [BITS-1:0]      r_peak_seed;
  logic [BITS-1:0]      r_peak_rec;
`else
  logic                 w_unused_path_rec;
  assign w_unused_path_rec = ^core.core_path_rec;
`endif

  logic w_num_max;
  logic w_last_seed;
  assign w_num_max   = &r_num;
  assign w_last_seed = (r_remaining == CNT_BITS'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_remaining <= '0;
      r_best_seed <= '0;
      r_best_len  <= '0;
      r_ovf_cnt   <= '0;
      r_wrapped   <= 1'b0;
      r_res_len   <= '0;
      r_res_ovf   <= 1'b0;
`ifdef COLLATZ_SWEEP_PEAK_EN
      r_res_rec   <= '0;
      r_peak_seed <= '0;
      r_peak_rec  <= '0;
`endif
    end else if (i_abort) begin
      // Statistics are deliberately left as they are so the host can read a partial sweep.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_num       <= i_seed_base;
            r_remaining <= i_count;
            r_best_seed <= '0;
            r_best_len  <= '0;
            r_ovf_cnt   <= '0;
            r_wrapped   <= 1'b0;
`ifdef COLLATZ_SWEEP_PEAK_EN
            r_peak_seed <= '0;
            r_peak_rec  <= '0;
`endif
            r_state     <= (i_count == '0) ? S_DONE : S_LAUNCH;
          end
        end
        S_LAUNCH: r_state <= S_WAIT;
        S_WAIT: begin
          if (core.core_done) begin
            r_res_len <= core.core_orbit_len;
            r_res_ovf <= core.core_overflow;
`ifdef COLLATZ_SWEEP_PEAK_EN
            r_res_rec <= core.core_path_rec;
`endif
            r_state   <= S_RECORD;
          end
        end
        S_RECORD: begin
          if (r_res_ovf) begin
            if (r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
          end else begin
            // Strict compare so that ties keep the earliest seed.
            if (r_res_len > r_best_len) begin
              r_best_len  <= r_res_len;
              r_best_seed <= r_num;
            end
`ifdef COLLATZ_SWEEP_PEAK_EN
            if (r_res_rec > r_peak_rec) begin
              r_peak_rec  <= r_res_rec;
              r_peak_seed <= r_num;
            end
`endif
          end
          r_remaining <= r_remaining - CNT_BITS'(1);
          if (w_last_seed) begin
            r_state <= S_DONE;
          end else if (w_num_max) begin
            // More seeds requested but the next one is not representable: stop rather than wrap to 0.
            r_wrapped <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_num   <= r_num + BITS'(1);
            r_state <= S_LAUNCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core.core_start = (r_state == S_LAUNCH) && !i_abort;
  assign core.core_num   = r_num;

  assign o_busy      = (r_state == S_LAUNCH) || (r_state == S_WAIT) || (r_state == S_RECORD);
  assign o_done      = (r_state == S_DONE);
  assign o_best_seed = r_best_seed;
  assign o_best_len  = r_best_len;
  assign o_ovf_cnt   = r_ovf_cnt;
  assign o_wrapped   = r_wrapped;
`ifdef COLLATZ_SWEEP_PEAK_EN
  assign o_peak_seed = r_peak_seed;
  assign o_peak_rec  = r_peak_rec;
`endif

endmodule

// File: tb/tb_collatz_sweep.sv
// tb/tb_collatz_sweep.sv - self-checking bench for collatz_sweep with a behavioural Collatz core
`timescale 1ns/1ps

module tb_collatz_sweep;
  localparam int BITS = 32;
  localparam int OLEN_BITS = 16;
  localparam int CNT_BITS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] seed_base = '0;
  logic [15:0] count = '0;
  logic        busy, done, wrapped;
  logic [31:0] best_seed;
  logic [15:0] best_len;
  logic [7:0]  ovf_cnt;
`ifdef COLLATZ_SWEEP_PEAK_EN
  logic [31:0] peak_seed, peak_rec;
`endif

  collatz_sweep_if #(.BITS(BITS), .OLEN_BITS(OLEN_BITS)) core_if ();

  collatz_sweep #(.BITS(BITS), .OLEN_BITS(OLEN_BITS), .CNT_BITS(CNT_BITS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_seed_base(seed_base), .i_count(count), .core(core_if),
    .o_busy(busy), .o_done(done), .o_best_seed(best_seed), .o_best_len(best_len),
    .o_ovf_cnt(ovf_cnt), .o_wrapped(wrapped)
`ifdef COLLATZ_SWEEP_PEAK_EN
    , .o_peak_seed(peak_seed), .o_peak_rec(peak_rec)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model controls
  logic [15:0] len_ovr [logic [31:0]];
  logic [15:0] ovf_mask = '0;
  logic        ovf_all = 1'b0;
  int          stall_from = -1;
  int          launches = 0;
  int          last_done = -1;
  int          min_gap = 1000;
  int          max_gap = 0;

  // Expected values from the reference sweep
  logic [31:0] e_seed, e_pseed, e_prec;
  logic [15:0] e_len;
  logic [7:0]  e_ovf;
  logic        e_wrap;
  int          e_launch;
  int          timed_out;

  typedef struct {
    logic [15:0] len;
    logic [31:0] rec;
    logic        ovf;
  } res_t;

  function automatic res_t core_model(logic [31:0] seed, int idx);
    longint unsigned v;
    int steps;
    res_t r;
    v = {32'd0, seed};
    steps = 0;
    r.len = '0;
    r.rec = seed;
    r.ovf = 1'b0;
    while (v > 1 && steps < 1000) begin
      if (v % 2 == 1) v = 3 * v + 1;
      else v = v / 2;
      steps++;
      if (v > 64'hFFFF_FFFF) r.ovf = 1'b1;
      else if (v[31:0] > r.rec) r.rec = v[31:0];
    end
    r.len = 16'(steps);
    if (len_ovr.exists(seed)) r.len = len_ovr[seed];
    if (ovf_all || (idx < 16 && ovf_mask[idx])) r.ovf = 1'b1;
    return r;
  endfunction

  task automatic ref_sweep(input logic [31:0] base, input int n);
    res_t r;
    longint unsigned s;
    e_seed = '0; e_len = '0; e_ovf = '0; e_wrap = 1'b0; e_launch = 0;
    e_pseed = '0; e_prec = '0;
    for (int i = 0; i < n; i++) begin
      s = {32'd0, base} + longint'(i);
      if (s > 64'hFFFF_FFFF) begin
        e_wrap = 1'b1;
        break;
      end
      e_launch++;
      r = core_model(s[31:0], i);
      if (r.ovf) begin
        if (e_ovf < 8'd255) e_ovf++;
      end else begin
        if (r.len > e_len) begin e_len = r.len; e_seed = s[31:0]; end
        if (r.rec > e_prec) begin e_prec = r.rec; e_pseed = s[31:0]; end
      end
    end
  endtask

  // Behavioural core: answers every launch after 1..4 cycles unless stalled.
  initial begin : responder
    res_t r;
    logic [31:0] num;
    int idx;
    core_if.core_done = 1'b0;
    core_if.core_orbit_len = '0;
    core_if.core_path_rec = '0;
    core_if.core_overflow = 1'b0;
    forever begin
      @(negedge clk);
      if (core_if.core_start === 1'b1) begin
        num = core_if.core_num;
        idx = launches;
        launches++;
        if (last_done >= 0) begin
          if (cyc - last_done < min_gap) min_gap = cyc - last_done;
          if (cyc - last_done > max_gap) max_gap = cyc - last_done;
        end
        if (stall_from < 0 || idx < stall_from) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          r = core_model(num, idx);
          core_if.core_done = 1'b1;
          core_if.core_orbit_len = r.len;
          core_if.core_path_rec = r.rec;
          core_if.core_overflow = r.ovf;
          last_done = cyc;
          @(negedge clk);
          core_if.core_done = 1'b0;
        end
      end
    end
  end

  task automatic launch_sweep(input logic [31:0] base, input logic [15:0] n);
    launches = 0; last_done = -1; min_gap = 1000; max_gap = 0;
    @(negedge clk);
    seed_base = base; count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0; seed_base = $urandom; count = 16'($urandom);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    timed_out = 0;
    while (done !== 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (done !== 1'b1) timed_out = 1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, wrapped, best_seed, best_len, ovf_cnt} !== '0) begin
      errors++; $display("FAIL reset outputs got %h want 0", {busy, done, wrapped, best_seed, best_len, ovf_cnt});
    end
    checks++;
    if ({core_if.core_start, core_if.core_num} !== '0) begin
      errors++; $display("FAIL reset core got %h want 0", {core_if.core_start, core_if.core_num});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    ref_sweep(32'd1, 10);
    launch_sweep(32'd1, 16'd10);
    wait_done();
    checks++; if (timed_out != 0) begin errors++; $display("FAIL basic timeout got %0d want 0", timed_out); end
    checks++; if (best_seed !== 32'd9 || best_seed !== e_seed) begin errors++; $display("FAIL basic best_seed got %0d want 9", best_seed); end
    checks++; if (best_len !== 16'd19 || best_len !== e_len) begin errors++; $display("FAIL basic best_len got %0d want 19", best_len); end
    checks++; if (ovf_cnt !== 8'd0 || wrapped !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic flags got ovf=%0d wrap=%0b busy=%0b want 0 0 0", ovf_cnt, wrapped, busy); end
    checks++; if (launches != 10) begin errors++; $display("FAIL basic launches got %0d want 10", launches); end
`ifdef COLLATZ_SWEEP_PEAK_EN
    checks++; if (peak_rec !== e_prec || peak_seed !== e_pseed) begin errors++; $display("FAIL basic peak got %0d/%0d want %0d/%0d", peak_seed, peak_rec, e_pseed, e_prec); end
`endif
  endtask

  task automatic test_ignore_done();
    @(negedge clk);
    core_if.core_done = 1'b1; core_if.core_orbit_len = 16'hFFFF; core_if.core_overflow = 1'b0;
    @(negedge clk);
    core_if.core_done = 1'b0;
    @(negedge clk);
    checks++; if (best_len !== 16'd19 || done !== 1'b1) begin errors++; $display("FAIL ignore_done got len=%0d done=%0b want 19 1", best_len, done); end
  endtask

  task automatic test_count_zero();
    launch_sweep(32'd5, 16'd0);
    checks++; if (done !== 1'b1 || best_len !== 16'd0) begin errors++; $display("FAIL count_zero got done=%0b len=%0d want 1 0", done, best_len); end
    repeat (5) @(negedge clk);
    checks++; if (launches != 0) begin errors++; $display("FAIL count_zero launches got %0d want 0", launches); end
  endtask

  task automatic test_tie();
    len_ovr[32'd8] = 16'd16;
    launch_sweep(32'd6, 16'd3);
    wait_done();
    checks++; if (timed_out != 0 || best_seed !== 32'd7 || best_len !== 16'd16) begin errors++; $display("FAIL tie got seed=%0d len=%0d want 7 16", best_seed, best_len); end
    len_ovr.delete();
  endtask

  task automatic test_overflow();
    logic [31:0] b;
    b = 32'($urandom_range(1, 200));
    ovf_mask = 16'b0110;
    ref_sweep(b, 5);
    launch_sweep(b, 16'd5);
    wait_done();
    checks++; if (timed_out != 0 || ovf_cnt !== 8'd2) begin errors++; $display("FAIL overflow cnt got %0d want 2", ovf_cnt); end
    checks++; if (best_seed !== e_seed || best_len !== e_len) begin errors++; $display("FAIL overflow best got %0d/%0d want %0d/%0d", best_seed, best_len, e_seed, e_len); end
    ovf_mask = '0;
  endtask

  task automatic test_saturate();
    ovf_all = 1'b1;
    launch_sweep(32'd1, 16'd300);
    wait_done();
    checks++; if (timed_out != 0 || ovf_cnt !== 8'd255 || best_len !== 16'd0) begin errors++; $display("FAIL saturate got ovf=%0d len=%0d want 255 0", ovf_cnt, best_len); end
    ovf_all = 1'b0;
  endtask

  task automatic test_wrap();
    ref_sweep(32'hFFFF_FFFE, 5);
    launch_sweep(32'hFFFF_FFFE, 16'd5);
    wait_done();
    checks++; if (timed_out != 0 || wrapped !== 1'b1 || e_wrap !== 1'b1) begin errors++; $display("FAIL wrap flag got %0b want 1", wrapped); end
    checks++; if (launches != 2 || launches != e_launch) begin errors++; $display("FAIL wrap launches got %0d want 2", launches); end
    checks++; if (ovf_cnt !== e_ovf || best_len !== e_len) begin errors++; $display("FAIL wrap stats got ovf=%0d len=%0d want %0d %0d", ovf_cnt, best_len, e_ovf, e_len); end
  endtask

  task automatic test_back_to_back();
    ref_sweep(32'd20, 6);
    launch_sweep(32'd20, 16'd6);
    repeat (3) @(negedge clk);
    start = 1'b1; seed_base = 32'd1000; count = 16'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    checks++; if (timed_out != 0 || min_gap != 2 || max_gap != 2) begin errors++; $display("FAIL turnaround got min=%0d max=%0d want 2 2", min_gap, max_gap); end
    checks++; if (best_seed !== e_seed || best_len !== e_len || launches != 6) begin errors++; $display("FAIL start_while_busy got %0d/%0d n=%0d want %0d/%0d n=6", best_seed, best_len, launches, e_seed, e_len); end
  endtask

  task automatic test_abort();
    int t;
    stall_from = 2;
    ref_sweep(32'd25, 2);
    launch_sweep(32'd25, 16'd8);
    t = 0;
    while (launches < 3 && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    checks++; if (launches != 3 || busy !== 1'b1) begin errors++; $display("FAIL abort setup got n=%0d busy=%0b want 3 1", launches, busy); end
    abort = 1'b1; start = 1'b1; seed_base = 32'd1; count = 16'd4;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort state got busy=%0b done=%0b want 0 0", busy, done); end
    repeat (10) @(negedge clk);
    checks++; if (launches != 3 || done !== 1'b0) begin errors++; $display("FAIL abort quiet got n=%0d done=%0b want 3 0", launches, done); end
    checks++; if (best_seed !== e_seed || best_len !== e_len) begin errors++; $display("FAIL abort stats got %0d/%0d want %0d/%0d", best_seed, best_len, e_seed, e_len); end
    stall_from = -1;
  endtask

  task automatic test_random();
    logic [31:0] b;
    int n;
    for (int k = 0; k < 6; k++) begin
      b = 32'($urandom_range(1, 5000));
      n = $urandom_range(1, 12);
      ovf_mask = 16'($urandom) & 16'h0FFF;
      ref_sweep(b, n);
      launch_sweep(b, 16'(n));
      wait_done();
      checks++;
      if (timed_out != 0 || best_seed !== e_seed || best_len !== e_len || ovf_cnt !== e_ovf || launches != e_launch) begin
        errors++;
        $display("FAIL random%0d got %0d/%0d ovf=%0d n=%0d want %0d/%0d ovf=%0d n=%0d", k, best_seed, best_len, ovf_cnt, launches, e_seed, e_len, e_ovf, e_launch);
      end
`ifdef COLLATZ_SWEEP_PEAK_EN
      checks++; if (peak_rec !== e_prec || peak_seed !== e_pseed) begin errors++; $display("FAIL random%0d peak got %0d/%0d want %0d/%0d", k, peak_seed, peak_rec, e_pseed, e_prec); end
`endif
    end
    ovf_mask = '0;
  endtask

  task automatic test_reset_mid();
    launch_sweep(32'd27, 16'd40);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, best_seed, best_len, ovf_cnt, core_if.core_start, core_if.core_num} !== '0) begin
      errors++; $display("FAIL reset_mid got busy=%0b len=%0d num=%0d want all 0", busy, best_len, core_if.core_num);
    end
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_done();
    test_count_zero();
    test_tie();
    test_overflow();
    test_saturate();
    test_wrap();
    test_back_to_back();
    test_abort();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
